// File: rtl/noisy_button_gen.sv
// Stimulus source for the push-button line: emits a burst of presses, each with
// LFSR-driven contact bounce on the press and release edges.
module noisy_button_gen #(
    parameter int unsigned BOUNCE_CYCLES = 16,
    parameter int unsigned TOGGLE_DIV    = 2,
    parameter int unsigned HOLD_CYCLES   = 32,
    parameter int unsigned GAP_CYCLES    = 20,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] press_count,
    output logic       boton,
    output logic       busy,
    output logic       done,
    output logic [7:0] presses_sent
);

    localparam int unsigned MAX_AB = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_C  = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
    localparam int unsigned CW     = $clog2(MAX_C);
    localparam int unsigned TW     = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;

    localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TOGGLE_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HELD,
        BOUNCE_OUT,
        GAP
    } state_t;

    state_t        state_q;
    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_d;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] tick_q;
    logic [7:0]    count_q;
    logic [7:0]    presses_sent_q;
    logic          boton_q;
    logic          busy_q;
    logic          done_q;

    // Galois step, right shift with taps 0xB400
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            lfsr_q         <= LFSR_SEED;
            cnt_q          <= '0;
            tick_q         <= '0;
            count_q        <= '0;
            presses_sent_q <= '0;
            boton_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                lfsr_q <= lfsr_d;
            end

            case (state_q)
                IDLE: begin
                    boton_q <= 1'b0;
                    if (start) begin
                        presses_sent_q <= '0;
                        if (press_count != 8'd0) begin
                            count_q <= press_count;
                            cnt_q   <= '0;
                            tick_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= BOUNCE_IN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end

                BOUNCE_IN, BOUNCE_OUT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (lfsr_q[0]) begin
                            boton_q <= ~boton_q;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                    // Last cycle of the window settles the level whatever the LFSR says
                    if (cnt_q == BOUNCE_LAST) begin
                        cnt_q  <= '0;
                        tick_q <= '0;
                        if (state_q == BOUNCE_IN) begin
                            boton_q <= 1'b1;
                            state_q <= HELD;
                        end else begin
                            boton_q        <= 1'b0;
                            presses_sent_q <= presses_sent_q + 8'd1;
                            state_q        <= GAP;
                        end
                    end
                end

                HELD: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q   <= '0;
                        tick_q  <= '0;
                        state_q <= BOUNCE_OUT;
                    end
                end

                GAP: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == GAP_LAST) begin
                        cnt_q  <= '0;
                        tick_q <= '0;
                        if (presses_sent_q == count_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= BOUNCE_IN;
                        end
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    boton_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign boton        = boton_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign presses_sent = presses_sent_q;

endmodule

// File: tb/tb_noisy_button_gen.sv
// Directed bench for noisy_button_gen: envelope timing, hand-computed bounce
// pattern for the default seed, reproducibility and async reset behaviour.
module tb_noisy_button_gen;

    localparam int P   = 84;
    localparam int LEN = 300;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] press_count = 8'd0;

    logic       boton, busy, done;
    logic [7:0] presses_sent;
    logic       boton_b, busy_b, done_b;
    logic [7:0] presses_sent_b;

    int checks = 0;
    int failures = 0;

    logic       tr_boton   [0:LEN-1];
    logic       tr_busy    [0:LEN-1];
    logic       tr_done    [0:LEN-1];
    logic [7:0] tr_ps      [0:LEN-1];
    logic       tr_boton_b [0:LEN-1];
    logic       tr_busy_b  [0:LEN-1];
    logic       ref_trace  [0:P-1];

    noisy_button_gen dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .press_count  (press_count),
        .boton        (boton),
        .busy         (busy),
        .done         (done),
        .presses_sent (presses_sent)
    );

    noisy_button_gen #(.LFSR_SEED(16'h0001)) dut_b (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .press_count  (press_count),
        .boton        (boton_b),
        .busy         (busy_b),
        .done         (done_b),
        .presses_sent (presses_sent_b)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Issues start with count n, then records len cycles; sample i is state-cycle i
    task automatic capture(input logic [7:0] n, input int len, input int mid);
        @(negedge clock);
        start = 1'b1;
        press_count = n;
        for (int i = 0; i < len; i++) begin
            @(negedge clock);
            tr_boton[i]   = boton;
            tr_busy[i]    = busy;
            tr_done[i]    = done;
            tr_ps[i]      = presses_sent;
            tr_boton_b[i] = boton_b;
            tr_busy_b[i]  = busy_b;
            start         = (i == mid);
            press_count   = (i == mid) ? 8'd7 : n;
        end
        start = 1'b0;
    endtask

    function automatic int ones(input int sel, input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) begin
            case (sel)
                0: c += int'(tr_boton[i]);
                1: c += int'(tr_busy[i]);
                2: c += int'(tr_done[i]);
                default: c += int'(tr_busy_b[i]);
            endcase
        end
        return c;
    endfunction

    function automatic int transitions(input int a);
        int c = 0;
        for (int i = a + 1; i <= a + 16; i++) begin
            if (tr_boton[i] != tr_boton[i-1]) c++;
        end
        return c;
    endfunction

    initial begin
        logic [15:0] bin_vec;
        int diffs;
        int max_t;

        // Reset state
        reset_n = 1'b0;
        #12;
        chk("rst_boton", 32'(boton), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ps", 32'(presses_sent), 0);
        do_reset();
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);

        // Single press, default seed
        capture(8'd1, 100, -1);
        chk("n1_busy_len", ones(1, 0, 99), P);
        chk("n1_busy_first", 32'(tr_busy[0]), 1);
        chk("n1_busy_end", 32'(tr_busy[P]), 0);
        bin_vec = '0;
        for (int i = 0; i < 16; i++) bin_vec[i] = tr_boton[i];
        chk("n1_bounce_in_trace", 32'(bin_vec), 32'h00C0);
        chk("n1_held_ones", ones(0, 16, 47), 32);
        chk("n1_gap_ones", ones(0, 64, 83), 0);
        chk("n1_level_after_in", 32'(tr_boton[16]), 1);
        chk("n1_level_after_out", 32'(tr_boton[64]), 0);
        chk("n1_trans_in_le9", 32'(transitions(0) <= 9), 1);
        chk("n1_trans_out_le9", 32'(transitions(48) <= 9), 1);
        chk("n1_done_count", ones(2, 0, 99), 1);
        chk("n1_done_at_end", 32'(tr_done[P]), 1);
        chk("n1_ps", 32'(tr_ps[P]), 1);
        chk("seedb_busy_len", ones(3, 0, 99), P);
        diffs = 0;
        for (int i = 0; i < P; i++) begin
            ref_trace[i] = tr_boton[i];
            if (tr_boton[i] != tr_boton_b[i]) diffs++;
        end
        chk("seedb_trace_differs", 32'(diffs != 0), 1);

        // Three presses with an ignored start mid-burst
        capture(8'd3, 260, 100);
        chk("n3_ps_cleared", 32'(tr_ps[0]), 0);
        chk("n3_busy_len", ones(1, 0, 259), 3 * P);
        chk("n3_busy_end", 32'(tr_busy[3*P]), 0);
        chk("n3_ps_1", 32'(tr_ps[64]), 1);
        chk("n3_ps_2", 32'(tr_ps[P+64]), 2);
        chk("n3_ps_3", 32'(tr_ps[2*P+64]), 3);
        chk("n3_done_count", ones(2, 0, 259), 1);
        chk("n3_done_at_end", 32'(tr_done[3*P]), 1);
        max_t = 0;
        for (int p = 0; p < 3; p++) begin
            if (transitions(p*P) > max_t) max_t = transitions(p*P);
            if (transitions(p*P + 48) > max_t) max_t = transitions(p*P + 48);
            chk($sformatf("n3_p%0d_in_level", p), 32'(tr_boton[p*P+16]), 1);
            chk($sformatf("n3_p%0d_out_level", p), 32'(tr_boton[p*P+64]), 0);
        end
        chk("n3_max_trans_le9", 32'(max_t <= 9), 1);

        // Zero-length burst
        capture(8'd0, 5, -1);
        chk("n0_done_first", 32'(tr_done[0]), 1);
        chk("n0_done_once", ones(2, 0, 4), 1);
        chk("n0_busy", ones(1, 0, 4), 0);
        chk("n0_boton", ones(0, 0, 4), 0);
        chk("n0_ps", 32'(tr_ps[0]), 0);

        // Async reset while HELD in the second press
        capture(8'd2, 114, -1);
        chk("midrst_pre_boton", 32'(tr_boton[113]), 1);
        chk("midrst_pre_ps", 32'(tr_ps[113]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_boton", 32'(boton), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ps", 32'(presses_sent), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        chk("midrst_lfsr_idle", 32'(dut.lfsr_q), 32'hACE1);
        chk("midrst_busy_after", 32'(busy), 0);
        chk("midrst_boton_after", 32'(boton), 0);

        // Same seed from reset must replay the first trace exactly
        capture(8'd1, 100, -1);
        diffs = 0;
        for (int i = 0; i < P; i++) begin
            if (tr_boton[i] != ref_trace[i]) diffs++;
        end
        chk("repeat_trace_diffs", 32'(diffs), 0);
        chk("repeat_busy_len", ones(1, 0, 99), P);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
